// File: rtl/high_radix_division.sv
// Radix-4 restoring divider: 32-bit unsigned dividend by 16-bit unsigned divisor.
// Retires two quotient bits per RUN cycle (16 cycles); divide-by-zero resolves
// straight from IDLE to DONE with a saturated quotient.
module high_radix_division (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [15:0] y,
    output logic [31:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] r_q, r_d;
    // Dividend shifts out of the top while quotient digits shift into the bottom.
    logic [31:0] xq_q, xq_d;
    logic [15:0] y_q, y_d;
    logic [31:0] quot_q, quot_d;
    logic [15:0] rem_q, rem_d;
    logic        dbz_q, dbz_d;

    logic [17:0] trial;
    logic [17:0] y1, y2, y3;
    logic [17:0] sub;
    logic [1:0]  digit;
    logic [15:0] r_new;

    // One radix-4 step: pick the largest multiple of y not exceeding the trial value.
    always_comb begin
        trial = {r_q, xq_q[31:30]};
        y1    = {2'b00, y_q};
        y2    = {1'b0, y_q, 1'b0};
        y3    = y1 + y2;
        if (trial >= y3) begin
            digit = 2'd3;
            sub   = y3;
        end else if (trial >= y2) begin
            digit = 2'd2;
            sub   = y2;
        end else if (trial >= y1) begin
            digit = 2'd1;
            sub   = y1;
        end else begin
            digit = 2'd0;
            sub   = '0;
        end
        // The true difference is below y (< 2^16), so the low 16 bits of the
        // operands alone give it exactly.
        r_new = trial[15:0] - sub[15:0];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        xq_d    = xq_q;
        y_d     = y_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xq_d  = x;
                    y_d   = y;
                    r_d   = '0;
                    cnt_d = '0;
                    if (y == 16'd0) begin
                        quot_d  = '1;
                        rem_d   = x[15:0];
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = r_new;
                xq_d  = {xq_q[29:0], digit};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    quot_d  = {xq_q[29:0], digit};
                    rem_d   = r_new;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            xq_q    <= '0;
            y_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            xq_q    <= xq_d;
            y_q     <= y_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule
